// File: rtl/ext_pkg.sv
// ext_pkg: shared types and the immediate-extension function for ext_pipe.
// Optional feature macro used by the top: EXT_PIPE_PERF_EN.
package ext_pkg;

    // Extension modes driven from decode.
    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_HIGH = 2'b10,
        EXT_SHL2 = 2'b11
    } ext_op_t;

    // Elastic buffer occupancy, encoded as {out_vld, skid_vld}.
    typedef enum logic [1:0] {
        EXT_ST_EMPTY = 2'b00,
        EXT_ST_ONE   = 2'b10,
        EXT_ST_FULL  = 2'b11
    } ext_state_t;

    // Widest OUT_W the extension function supports.
    localparam int unsigned EXT_MAX_W = 64;

    // Extends the low in_w bits of imm; the caller keeps the low out_w bits.
    function automatic logic [EXT_MAX_W-1:0] ext_apply(
        input logic [EXT_MAX_W-1:0] imm,
        input ext_op_t              op,
        input int unsigned          in_w,
        input int unsigned          out_w
    );
        logic [EXT_MAX_W-1:0] zext;
        logic [EXT_MAX_W-1:0] sext;
        logic [EXT_MAX_W-1:0] res;
        int unsigned          pad;
        pad  = EXT_MAX_W - in_w;
        // Park the immediate at the top, then shift back down logically or arithmetically.
        zext = (imm << pad) >> pad;
        sext = $signed(imm << pad) >>> pad;
        case (op)
            EXT_ZERO: res = zext;
            EXT_SIGN: res = sext;
            EXT_HIGH: res = zext << (out_w - in_w);
            EXT_SHL2: res = sext << 2;
            default:  res = zext;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ext_skid.sv
// ext_skid: two-entry valid/ready elastic buffer (output register plus skid register).
// in_ready comes straight from a flop, so there is no combinational ready path.
module ext_skid
    import ext_pkg::*;
#(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    ext_state_t       state_q;
    ext_state_t       state_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             accept;
    logic             deliver;
    logic             out_ld;
    logic             skid_ld;
    logic             skid_to_out;

    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign out_data  = out_data_q;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    // Next occupancy and which register loads on this edge.
    always_comb begin
        state_d     = state_q;
        out_ld      = 1'b0;
        skid_ld     = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            EXT_ST_EMPTY: begin
                if (accept) begin
                    out_ld  = 1'b1;
                    state_d = EXT_ST_ONE;
                end
            end
            EXT_ST_ONE: begin
                if (accept && deliver) begin
                    out_ld = 1'b1;
                end else if (accept) begin
                    skid_ld = 1'b1;
                    state_d = EXT_ST_FULL;
                end else if (deliver) begin
                    state_d = EXT_ST_EMPTY;
                end
            end
            EXT_ST_FULL: begin
                if (deliver) begin
                    skid_to_out = 1'b1;
                    state_d     = EXT_ST_ONE;
                end
            end
            default: state_d = EXT_ST_EMPTY;
        endcase
    end

    // Occupancy register; reset drops any held items.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXT_ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers change only on accept or skid-to-output transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            if (out_ld) begin
                out_data_q <= in_data;
            end else if (skid_to_out) begin
                out_data_q <= skid_data_q;
            end
            if (skid_ld) begin
                skid_data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate extender between decode and the operand mux.
// Define EXT_PIPE_PERF_EN to add perf_items / perf_stalls counters.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
`ifdef EXT_PIPE_PERF_EN
    output logic [31:0]      perf_items,
    output logic [31:0]      perf_stalls,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PAY_W = OUT_W + TAG_W;

    logic [EXT_MAX_W-1:0] imm_wide;
    logic [EXT_MAX_W-1:0] ext_wide;
    logic [OUT_W-1:0]     ext_data;
    logic [PAY_W-1:0]     pay_in;
    logic [PAY_W-1:0]     pay_out;

    assign imm_wide = EXT_MAX_W'(in_imm);
    assign ext_wide = ext_apply(imm_wide, ext_op_t'(in_op), IN_W, OUT_W);
    assign ext_data = ext_wide[OUT_W-1:0];
    assign pay_in   = {in_tag, ext_data};
    assign {out_tag, out_data} = pay_out;

    ext_skid #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

`ifdef EXT_PIPE_PERF_EN
    logic [31:0] items_q;
    logic [31:0] stalls_q;

    // Delivered-item and backpressure-cycle counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            items_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (out_valid && out_ready) begin
                items_q <= items_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign perf_items  = items_q;
    assign perf_stalls = stalls_q;
`endif

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate extender for the MIPS datapath, placed between the decode stage and the operand mux.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes.
- Carries a sideband tag and uses a valid/ready handshake.
- Contains a two-entry elastic buffer (output register plus skid register), so it sustains one item per cycle under backpressure with no combinational ready path.

Parameters:
IN_W, 16, immediate input width; legal range 2 to OUT_W-2
OUT_W, 32, extended output width
TAG_W, 5, sideband tag width (destination register id); carried unchanged

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input item present
in_ready  out  1  block can accept an item
in_imm  in  IN_W  raw immediate
in_op  in  2  extension mode
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result
out_data  out  OUT_W  extended result
out_tag  out  TAG_W  tag of the result

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high on rst; rst is sampled only at the rising edge of clk.
- Extension modes (in_op), computed combinationally on input and registered:
  - 00 ZERO: out = {0, imm}
  - 01 SIGN: out = replicate imm[IN_W-1], then imm
  - 10 HIGH: imm occupies [OUT_W-1:OUT_W-IN_W]; lower bits are 0 (LUI)
  - 11 SHL2: sign-extend, then shift left 2, truncated to OUT_W (branch offset)
- Handshake:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - in_ready is a register output equal to !skid_valid.
  - out_valid/out_data/out_tag are held stable while out_valid && !out_ready.
- Latency: 1 cycle, accept edge to out_valid high, when empty.
- States (out_vld, skid_vld):
  - EMPTY (0,0):
    - accept -> ONE; result loads into the output register.
  - ONE (1,0):
    - accept and deliver -> ONE; new result replaces the output register.
    - accept, no deliver -> FULL; new result goes to the skid register; in_ready drops next cycle.
    - deliver only -> EMPTY.
    - neither -> ONE.
  - FULL (1,1):
    - no accept possible (in_ready=0).
    - deliver -> ONE; skid moves to the output register; in_ready rises next cycle.
    - no deliver -> FULL.
- Ordering: strict FIFO order; tag always travels with its data.
- Reset values: out_valid=0, out_data=0, out_tag=0, in_ready=1 in the cycle after reset. Skid register cleared.
- Reset mid-operation: all held items are discarded, with no delivery. A handshake in the reset cycle is ignored.
- in_op/in_imm/in_tag are don't-care when in_valid=0. The registers update only on accept or transfer.

Optional Feature:
- Macro: EXT_PIPE_PERF_EN
- Defined:
  - Adds outputs perf_items (32) and perf_stalls (32), both reset to 0 by rst.
  - perf_items increments on each delivery.
  - perf_stalls increments each cycle with out_valid && !out_ready.
  - Both counters wrap at 2^32.
- Undefined: no such ports or logic. Datapath behaviour is identical either way.

Decomposition:
- Package ext_pkg holds:
  - ext_op_t enum: EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_HIGH=2'b10, EXT_SHL2=2'b11
  - state encoding constants
  - pure function ext_apply(imm, op), parametrised by width
- One natural sub-module: ext_skid (generic two-entry valid/ready elastic buffer, payload width OUT_W+TAG_W). ext_pipe wraps it with the mode logic.

Test Plan:
- Modes, out_ready=1, in_imm=16'hC08F, tag 3:
  - op 00 -> 32'h0000C08F
  - op 01 -> 32'hFFFFC08F
  - op 10 -> 32'hC08F0000
  - op 11 -> 32'hFFFF023C
  - each arrives 1 cycle after accept, tag=3.
- Positive immediate, in_imm=16'h7FFF:
  - SIGN -> 32'h00007FFF
  - SHL2 -> 32'h0001FFFC
- Backpressure:
  - Stream imm 1,2,3,4 (tags 1..4) with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - Raise out_ready -> outputs 1,2,3,4 in order; no loss, no duplicates; out_data stable during stall.
- Full throughput: in_valid=1 and out_ready=1 for 8 cycles -> 8 items delivered on consecutive cycles.
- Reset mid-operation:
  - Fill to FULL, then assert rst for one cycle.
  - Next cycle: out_valid=0, in_ready=1, out_data=0; no held item ever appears.
- EXT_PIPE_PERF_EN: in the backpressure scenario, perf_items=4. perf_stalls equals the number of cycles with out_valid && !out_ready during the stall: 2 if the first accept is issued in the first stall cycle.
